// File: rtl/m_wb_sram8_bridge.sv
// m_wb_sram8_bridge: Wishbone classic slave that serves core cycles from an 8-bit asynchronous SRAM,
// one external byte access per lane, with ACK and read data returned once all lanes are done.
module m_wb_sram8_bridge #(
    parameter int ADRW       = 17,
    parameter int IWIDTH     = 32,
    parameter int WAITSTATES = 1
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    input  logic [31:0]       ADR_I,
    input  logic [31:0]       DAT_I,
    input  logic [3:0]        SEL_I,
    output logic              ACK_O,
    output logic [IWIDTH-1:0] DAT_O,
    output logic [ADRW-1:0]   sram_a,
    output logic [7:0]        sram_dq_o,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;
    state_t          state_q;
    logic            we_q, abort_q;
    logic [ADRW-1:0] adr_q;
    logic [31:0]     dat_q, rd_q;
    logic [3:0]      rem_q;
    logic [1:0]      lane_q;
    logic [2:0]      cnt_q;
    logic            req, idle, src_we, src_narrow, last_strobe, stop;
    logic [ADRW-1:0] src_adr, nxt_a;
    logic [31:0]     src_dat;
    logic [3:0]      src_mask;
    logic [1:0]      nxt_lane;
    logic [7:0]      nxt_byte;
    logic            unused_adr;

    assign req         = CYC_I && STB_I;
    assign idle        = state_q == IDLE;
    assign last_strobe = cnt_q == 3'(WAITSTATES);
    assign stop        = abort_q || !req;
    assign unused_adr  = ^ADR_I[31:ADRW];
    assign DAT_O       = rd_q[IWIDTH-1:0];

    // Next lane comes from the live request when idle, else from the remaining-lane mask
    always_comb begin
        src_we     = idle ? WE_I : we_q;
        src_adr    = idle ? ADR_I[ADRW-1:0] : adr_q;
        src_dat    = idle ? DAT_I : dat_q;
        src_mask   = idle ? (WE_I ? SEL_I : (IWIDTH == 32 ? 4'hF : 4'h1)) : rem_q;
        src_narrow = !src_we && IWIDTH == 8;
        nxt_lane   = src_mask[0] ? 2'd0 : src_mask[1] ? 2'd1 : src_mask[2] ? 2'd2 : 2'd3;
        nxt_a      = src_narrow ? src_adr : {src_adr[ADRW-1:2], nxt_lane};
        nxt_byte   = src_dat[{nxt_lane, 3'b000} +: 8];
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= IDLE;
            ACK_O      <= 1'b0;
            rd_q       <= '0;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            we_q       <= 1'b0;
            abort_q    <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rem_q      <= '0;
            lane_q     <= '0;
            cnt_q      <= '0;
        end else begin
            ACK_O <= 1'b0;
            case (state_q)
                IDLE: if (req && !ACK_O) begin
                    we_q    <= WE_I;
                    adr_q   <= ADR_I[ADRW-1:0];
                    dat_q   <= DAT_I;
                    abort_q <= 1'b0;
                    if (src_mask == '0) begin
                        state_q <= ACK;
                    end else begin
                        state_q    <= SETUP;
                        lane_q     <= nxt_lane;
                        rem_q      <= src_mask & (src_mask - 4'd1);
                        sram_a     <= nxt_a;
                        sram_dq_o  <= nxt_byte;
                        sram_dq_oe <= WE_I;
                        sram_ce_n  <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q   <= STROBE;
                    cnt_q     <= '0;
                    sram_we_n <= !we_q;
                    sram_oe_n <= we_q;
                    abort_q   <= stop;
                end
                STROBE: begin
                    abort_q <= stop;
                    if (!last_strobe) begin
                        cnt_q <= cnt_q + 3'd1;
                    end else begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (!we_q) rd_q[{lane_q, 3'b000} +: 8] <= sram_dq_i;
                        if (stop || rem_q == '0) begin
                            state_q    <= stop ? IDLE : ACK;
                            sram_ce_n  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                        end else begin
                            state_q   <= SETUP;
                            lane_q    <= nxt_lane;
                            rem_q     <= src_mask & (src_mask - 4'd1);
                            sram_a    <= nxt_a;
                            sram_dq_o <= nxt_byte;
                        end
                    end
                end
                ACK: begin
                    ACK_O   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_wb_sram8_bridge.sv
// tb_m_wb_sram8_bridge: drives a 32-bit/1-waitstate and an 8-bit/0-waitstate bridge from one bus,
// sharing one SRAM model and a byte-array reference memory.
module tb_m_wb_sram8_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0, use8 = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        ack32, ack8, dqoe32, dqoe8, ce32, ce8, oe32, oe8, we32, we8;
    logic [31:0] dato32;
    logic [7:0]  dato8, dqo32, dqo8, dq_in;
    logic [16:0] a32, a8;
    logic        ack, dqoe, ce_n, oe_n, we_n;
    logic [31:0] dato;
    logic [16:0] a;
    logic [7:0]  dqo;
    bit   [7:0]  mem [0:131071];
    bit   [7:0]  ref_mem [0:131071];
    int          total = 0, passed = 0, fails = 0, cur_ws = 1, st_len = 0;
    logic [31:0] exp32 = '0;
    logic [7:0]  exp8 = '0;
    logic        prev_st = 1'b0;
    logic [16:0] st_a = '0;
    logic [16:0] ev_a[$];
    logic [7:0]  ev_d[$];
    logic        ev_w[$];

    m_wb_sram8_bridge #(.ADRW(17), .IWIDTH(32), .WAITSTATES(1)) dut32 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc && !use8), .STB_I(stb), .WE_I(we), .ADR_I(adr),
        .DAT_I(dat), .SEL_I(sel), .ACK_O(ack32), .DAT_O(dato32), .sram_a(a32), .sram_dq_o(dqo32),
        .sram_dq_i(dq_in), .sram_dq_oe(dqoe32), .sram_ce_n(ce32), .sram_oe_n(oe32), .sram_we_n(we32));

    m_wb_sram8_bridge #(.ADRW(17), .IWIDTH(8), .WAITSTATES(0)) dut8 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc && use8), .STB_I(stb), .WE_I(we), .ADR_I(adr),
        .DAT_I(dat), .SEL_I(sel), .ACK_O(ack8), .DAT_O(dato8), .sram_a(a8), .sram_dq_o(dqo8),
        .sram_dq_i(dq_in), .sram_dq_oe(dqoe8), .sram_ce_n(ce8), .sram_oe_n(oe8), .sram_we_n(we8));

    assign ack   = use8 ? ack8 : ack32;
    assign dato  = use8 ? {24'h0, dato8} : dato32;
    assign a     = use8 ? a8 : a32;
    assign dqo   = use8 ? dqo8 : dqo32;
    assign dqoe  = use8 ? dqoe8 : dqoe32;
    assign ce_n  = use8 ? ce8 : ce32;
    assign oe_n  = use8 ? oe8 : oe32;
    assign we_n  = use8 ? we8 : we32;
    assign dq_in = (!ce_n && !oe_n) ? mem[a] : 8'hxx;

    always @(posedge clk) if (!ce_n && !we_n && dqoe) mem[a] <= dqo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample on the falling edge, log each strobe pulse, check bus invariants
    task automatic step();
        logic st;
        @(negedge clk);
        st = !oe_n || !we_n;
        if (st && !prev_st) begin
            ev_a.push_back(a);
            ev_d.push_back(dqo);
            ev_w.push_back(!we_n);
            st_len = 1;
            st_a = a;
            chk("strobe_ce", 32'(ce_n), 32'd0);
            if (!we_n) chk("write_dqoe", 32'(dqoe), 32'd1);
        end else if (st) begin
            st_len++;
            chk("addr_hold", 32'(a), 32'(st_a));
        end
        if (!st && prev_st) chk("strobe_len", 32'(st_len), 32'(cur_ws + 1));
        prev_st = st;
        chk("we_oe_excl", 32'(!we_n && !oe_n), 32'd0);
        chk("dqoe_vs_oe", 32'(dqoe && !oe_n), 32'd0);
    endtask

    task automatic idle(input int n);
        cyc = 1'b0;
        stb = 1'b0;
        repeat (n) begin
            step();
            chk("idle_ack", 32'(ack), 32'd0);
            chk("idle_ce", 32'(ce_n), 32'd1);
        end
    endtask

    task automatic chk_rst();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dato, 32'd0);
        chk("rst_ce", 32'(ce_n), 32'd1);
        chk("rst_oe", 32'(oe_n), 32'd1);
        chk("rst_we", 32'(we_n), 32'd1);
        chk("rst_dqoe", 32'(dqoe), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_dqo", 32'(dqo), 32'd0);
    endtask

    // Reference: lane list, byte addresses and data effects derived from the request alone
    task automatic txn(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s);
        int          lanes[$];
        logic [16:0] ea[$];
        logic [7:0]  ed[$];
        logic [16:0] ba;
        int          edges;
        cur_ws = use8 ? 0 : 1;
        for (int i = 0; i < 4; i++) if (w ? s[i] : !use8) lanes.push_back(i);
        if (!w && use8) lanes.push_back(-1);
        foreach (lanes[i]) begin
            ba = lanes[i] < 0 ? ad[16:0] : {ad[16:2], 2'(lanes[i])};
            ea.push_back(ba);
            if (w) begin
                ed.push_back(d[8*lanes[i] +: 8]);
                ref_mem[ba] = d[8*lanes[i] +: 8];
            end else begin
                ed.push_back(ref_mem[ba]);
                if (use8) exp8 = ref_mem[ba];
                else exp32[8*lanes[i] +: 8] = ref_mem[ba];
            end
        end
        ev_a.delete();
        ev_d.delete();
        ev_w.delete();
        we = w;
        adr = ad;
        dat = d;
        sel = s;
        cyc = 1'b1;
        stb = 1'b1;
        edges = 0;
        do begin
            step();
            edges++;
        end while (ack !== 1'b1 && edges < 200);
        chk("ack_latency", 32'(edges - 1), 32'(lanes.size() * (cur_ws + 2) + 1));
        chk("dat_o", dato, use8 ? {24'h0, exp8} : exp32);
        step();
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("n_access", 32'(ev_a.size()), 32'(ea.size()));
        foreach (ea[i]) if (i < ev_a.size()) begin
            chk("acc_addr", 32'(ev_a[i]), 32'(ea[i]));
            chk("acc_dir", 32'(ev_w[i]), 32'(w));
            if (w) begin
                chk("acc_wdata", 32'(ev_d[i]), 32'(ed[i]));
                chk("sram_byte", 32'(mem[ea[i]]), 32'(ed[i]));
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            use8 = u[0];
            repeat (5) begin
                step();
                chk_rst();
            end
        end
        use8 = 1'b0;
        txn(1'b1, 32'h104, 32'h44332211, 4'hF);
        idle(2);
        txn(1'b0, 32'h104, 32'h0, 4'h0);
        chk("plan_rd32", dato, 32'h44332211);
        idle(1);
        txn(1'b1, 32'h200, 32'hAABBCCDD, 4'b0101);
        chk("plan_wr_count", 32'(ev_a.size()), 32'd2);
        chk("plan_wr_keep", dato, 32'h44332211);
        txn(1'b1, 32'h300, 32'h12345678, 4'b0000);
        txn(1'b0, 32'h104, 32'h0, 4'h0);
        txn(1'b1, 32'h0, 32'h5A000000, 4'b1000);
        idle(2);
        use8 = 1'b1;
        txn(1'b0, 32'h3, 32'h0, 4'h0);
        chk("plan_rd8", dato, 32'h5A);
        for (int k = 0; k < 60; k++) begin
            if (k == 30) begin
                idle(2);
                use8 = 1'b0;
            end
            txn(1'($urandom_range(0, 1)), ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 63)),
                $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        cur_ws = 1;
        ev_a.delete();
        we = 1'b0;
        adr = 32'h104;
        cyc = 1'b1;
        stb = 1'b1;
        repeat (4) step();
        stb = 1'b0;
        repeat (20) begin
            step();
            chk("abort_no_ack", 32'(ack), 32'd0);
        end
        chk("abort_accesses", 32'(ev_a.size()), 32'd2);
        chk("abort_ce", 32'(ce_n), 32'd1);
        chk("abort_dqoe", 32'(dqoe), 32'd0);
        exp32[15:0] = {ref_mem[17'h105], ref_mem[17'h104]};
        idle(2);
        adr = 32'h200;
        cyc = 1'b1;
        stb = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk_rst();
        rst = 1'b0;
        exp32 = '0;
        idle(15);
        txn(1'b0, 32'h200, 32'h0, 4'h0);
        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
